// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad / counter blocks.
package microwave_pkg;

  localparam int BCD_W        = 4;
  localparam int KEY_W        = 10;
  localparam int ENTRY_DIGITS = 3;

  // Keypad FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    DEBOUNCE = ST_DEBOUNCE,
    PRESSED  = ST_PRESSED,
    RELEASE  = ST_RELEASE
  } kp_state_e;

  // Entry register: [2]=mins, [1]=sec_tens, [0]=sec_ones
  typedef logic [ENTRY_DIGITS-1:0][BCD_W-1:0] entry_t;

  // Digit count saturates at three entered digits
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/keypad_encoder.sv
// One-hot key lines to BCD, with a flag marking exactly-one-key-down.
module keypad_encoder
  import microwave_pkg::*;
(
  input  logic [KEY_W-1:0] keys,
  output logic [BCD_W-1:0] bcd,
  output logic             onehot
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  always_comb begin
    onehot = (keys != '0) && ((keys & (keys - KEY_W'(1))) == '0);
  end

  // OR of indices of set bits; only meaningful when onehot is high
  always_comb begin
    bcd = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (keys[i]) bcd = bcd | BCD_W'(i);
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: sync, debounce, BCD encode and right-to-left digit entry
// feeding the minutes/seconds counter load port.
module keypad_entry
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [KEY_W-1:0] keypad,
  input  logic             mag_on,
  output logic [BCD_W-1:0] d_mins,
  output logic [BCD_W-1:0] d_sec_tens,
  output logic [BCD_W-1:0] d_sec_ones,
  output logic [BCD_W-1:0] digit,
  output logic             key_valid,
  output logic             loadn,
  output logic [1:0]       digit_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser; ks is the only view of the keypad used downstream
  logic [1:0][KEY_W-1:0] sync_pipe;
  logic [KEY_W-1:0]      ks;

  kp_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [KEY_W-1:0] pat, pat_nx;
  logic             accept;

  logic [BCD_W-1:0] ks_bcd;
  logic             ks_onehot;

  entry_t entry;

  assign ks = sync_pipe[1];

  // Accept only fires while ks==pat, so encoding ks yields BCD(pat)
  keypad_encoder u_enc (
    .keys   (ks),
    .bcd    (ks_bcd),
    .onehot (ks_onehot)
  );

  // Synchroniser shift register
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[0], keypad};
  end

  // FSM state, debounce counter and captured pattern
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pat   <= pat_nx;
    end
  end

  // Debounce next-state: press and release both need DEBOUNCE_CYCLES samples
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pat_nx   = pat;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (ks_onehot) begin
          pat_nx   = ks;
          cnt_nx   = CNT_W'(1);
          state_nx = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks == pat) begin
          if (cnt == CNT_LAST) begin
            state_nx = PRESSED;
            accept   = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      PRESSED: begin
        // Held keys (or extra keys piling on) never re-accept
        if (ks == '0) begin
          cnt_nx   = CNT_W'(1);
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (ks == '0) begin
          if (cnt == CNT_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end else begin
          state_nx = PRESSED;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Entry shift, load strobe and digit bookkeeping on an accepted key;
  // with the magnetron running only the digit readout updates
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      entry       <= '0;
      digit       <= '0;
      digit_count <= '0;
      key_valid   <= 1'b0;
      loadn       <= 1'b1;
    end else begin
      key_valid <= 1'b0;
      loadn     <= 1'b1;
      if (accept) begin
        digit <= ks_bcd;
        if (!mag_on) begin
          entry       <= {entry[ENTRY_DIGITS-2:0], ks_bcd};
          digit_count <= sat_inc(digit_count);
          key_valid   <= 1'b1;
          loadn       <= 1'b0;
        end
      end
    end
  end

  assign d_mins     = entry[2];
  assign d_sec_tens = entry[1];
  assign d_sec_ones = entry[0];

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: press table plus latency, bounce and
// reset-while-held sequences.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       mag_on = 1'b0;
  logic [9:0] keypad = '0;
  logic [3:0] d_mins, d_sec_tens, d_sec_ones, digit;
  logic       key_valid, loadn;
  logic [1:0] digit_count;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  keypad_entry dut (
    .clk         (clk),
    .clearn      (clearn),
    .keypad      (keypad),
    .mag_on      (mag_on),
    .d_mins      (d_mins),
    .d_sec_tens  (d_sec_tens),
    .d_sec_ones  (d_sec_ones),
    .digit       (digit),
    .key_valid   (key_valid),
    .loadn       (loadn),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] keys;
    logic       mag;
    int         hold;
    int         exp_pulses;
    logic [3:0] mins, tens, ones, dig;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge; counts pulses and checks strobe pairing
  task automatic tick();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulses++;
    chk("loadn_vs_valid", {15'd0, loadn}, {15'd0, ~key_valid});
  endtask

  task automatic chk_regs(input string nm, input logic [3:0] m, input logic [3:0] t,
                          input logic [3:0] o, input logic [3:0] dg, input logic [1:0] c);
    chk({nm, "_mins"},  {12'd0, d_mins},      {12'd0, m});
    chk({nm, "_tens"},  {12'd0, d_sec_tens},  {12'd0, t});
    chk({nm, "_ones"},  {12'd0, d_sec_ones},  {12'd0, o});
    chk({nm, "_digit"}, {12'd0, digit},       {12'd0, dg});
    chk({nm, "_count"}, {14'd0, digit_count}, {14'd0, c});
  endtask

  initial begin
    int first;

    // Entry state after key 5: mins=0 tens=0 ones=5 count=1
    vecs[0] = '{10'h002, 1'b0, 20, 1, 4'd0, 4'd5, 4'd1, 4'd1, 2'd2};
    vecs[1] = '{10'h004, 1'b0, 20, 1, 4'd5, 4'd1, 4'd2, 4'd2, 2'd3};
    vecs[2] = '{10'h008, 1'b0, 20, 1, 4'd1, 4'd2, 4'd3, 4'd3, 2'd3};
    vecs[3] = '{10'h010, 1'b0, 20, 1, 4'd2, 4'd3, 4'd4, 4'd4, 2'd3};
    vecs[4] = '{10'h108, 1'b0, 30, 0, 4'd2, 4'd3, 4'd4, 4'd4, 2'd3};
    vecs[5] = '{10'h100, 1'b0, 20, 1, 4'd3, 4'd4, 4'd8, 4'd8, 2'd3};
    vecs[6] = '{10'h200, 1'b1, 20, 0, 4'd3, 4'd4, 4'd8, 4'd9, 2'd3};
    vecs[7] = '{10'h001, 1'b0, 20, 1, 4'd4, 4'd8, 4'd0, 4'd0, 2'd3};
    vecs[8] = '{10'h200, 1'b0, 20, 1, 4'd8, 4'd0, 4'd9, 4'd9, 2'd3};

    // Reset state
    repeat (3) tick();
    chk_regs("reset", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    chk("reset_valid", {15'd0, key_valid}, 16'd0);
    chk("reset_loadn", {15'd0, loadn}, 16'd1);

    // Key 5 stable before edge 1: pulse must appear right after edge 6
    clearn = 1'b1;
    keypad = 10'h020;
    pulses = 0;
    first  = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (key_valid === 1'b1 && first == 0) first = e;
    end
    chk("latency_edge", 16'(first), 16'd6);
    keypad = '0;
    repeat (12) tick();
    chk("key5_pulses", 16'(pulses), 16'd1);
    chk_regs("key5", 4'd0, 4'd0, 4'd5, 4'd5, 2'd1);

    // Press table
    for (int i = 0; i < 9; i++) begin
      mag_on = vecs[i].mag;
      keypad = vecs[i].keys;
      pulses = 0;
      repeat (vecs[i].hold) tick();
      keypad = '0;
      repeat (12) tick();
      mag_on = 1'b0;
      chk($sformatf("row%0d_pulses", i), 16'(pulses), 16'(vecs[i].exp_pulses));
      chk_regs($sformatf("row%0d", i), vecs[i].mins, vecs[i].tens, vecs[i].ones,
               vecs[i].dig, vecs[i].cnt);
    end

    // Bounce on key 7: two-cycle runs never reach four stable samples
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      keypad = ((k % 4) < 2) ? 10'h080 : 10'h000;
      tick();
    end
    chk("bounce_pulses", 16'(pulses), 16'd0);
    keypad = 10'h080;
    repeat (20) tick();
    chk("bounce_held_pulses", 16'(pulses), 16'd1);
    keypad = '0;
    repeat (12) tick();
    chk_regs("bounce", 4'd0, 4'd9, 4'd7, 4'd7, 2'd3);

    // Reset while key 6 held after acceptance
    keypad = 10'h040;
    pulses = 0;
    repeat (10) tick();
    chk("k6_pre_pulses", 16'(pulses), 16'd1);
    #2;
    clearn = 1'b0;
    #1;
    chk_regs("midreset", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
    chk("midreset_valid", {15'd0, key_valid}, 16'd0);
    chk("midreset_loadn", {15'd0, loadn}, 16'd1);
    repeat (3) tick();
    clearn = 1'b1;
    pulses = 0;
    repeat (20) tick();
    chk("k6_reaccept_pulses", 16'(pulses), 16'd1);
    chk_regs("k6_reaccept", 4'd0, 4'd0, 4'd6, 4'd6, 2'd1);
    keypad = '0;
    repeat (12) tick();
    chk("k6_total_pulses", 16'(pulses), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
